counter_arbiter: RTL and testbench
==================================

// Module: counter_arbiter
// PURPOSE
//  Shares one internal DWIDTH-bit up-counter among NREQ requesters. Each requester
//  raises req with its own terminal count. The block grants the counter round-robin,
//  runs the count, pulses that requester's done, then re-arbitrates.
//  Sits between several client FSMs and a single counting resource; replaces per-client counters.
// PARAMETERS
//  NREQ    4  number of requesters (>=2)
//  DWIDTH  7  counter / count-value width in bits
//  IDW     2  owner index width, = $clog2(NREQ)
// PORTS
//  clk        in   1            single clock; all state updates on rising edge
//  rst        in   1            synchronous, active-high reset
//  req_i      in   NREQ         level request per requester; bit k = requester k
//  cnt_val_i  in   NREQ*DWIDTH  count value; requester k at [k*DWIDTH +: DWIDTH]
//  grant_o    out  NREQ         one-hot owner of the counter; all zero when idle
//  done_o     out  NREQ         1-cycle pulse to the owner when its count completes
//  busy_o     out  1            counter is owned (state != IDLE)
//  owner_o    out  IDW          index of current owner; holds last owner when idle
//  cnt_o      out  DWIDTH       current counter value
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, grant_o=0, done_o=0, busy_o=0, owner_o=0, cnt_o=0, rr pointer=0.
//   Reset mid-RUN/DONE aborts the count; no done_o pulse is generated.
//  FSM: IDLE -> RUN -> DONE -> IDLE. Also IDLE -> DONE when the latched value is 0.
//   IDLE: if any req_i, pick winner k by round-robin from the rr pointer (inclusive, ascending, wrapping).
//     On that edge: grant_o=1<<k, owner_o=k, target=cnt_val_i[k], cnt_o=0.
//     Next state is RUN, or DONE if target==0.
//   RUN: cnt_o increments by 1 each cycle. The cycle with cnt_o==target-1 moves to DONE.
//     cnt_o holds target-1 in DONE.
//   DONE: done_o[owner]=1 for exactly this cycle, and grant_o stays asserted.
//     On exit: grant_o=0, rr pointer=(owner+1) mod NREQ, state=IDLE.
//  Timing: req seen high in IDLE cycle n gives grant at n+1.
//   cnt_o runs 0..V-1 over cycles n+1..n+V; done_o is at n+V+1; idle at n+V+2.
//   With V=0, done_o is at n+1.
//  req_i and cnt_val_i are sampled only in IDLE. The target is latched at grant.
//   Changes to cnt_val_i or deassertion of req during RUN/DONE are ignored; the count completes.
//  The requester must drop req_i on done_o. If still high in the next IDLE it is a new request;
//   the rr pointer gives other requesters priority, and a sole requester is re-served.
//  Simultaneous requests: one grant per arbitration. No requester waits more than NREQ-1 services.
//  Every IDLE cycle is a visible 1-cycle gap between services (no back-to-back grant).
//  Width: the counter never exceeds target-1 <= 2^DWIDTH-2, so it never wraps.
//   A target of 2^DWIDTH-1 runs the full count.
//  done_o and grant_o are never asserted for two different requesters at once.
// TESTING
//  1 rst, then req_i=0001, val0=5 -> grant_o=0001 for 6 cycles, cnt_o 0,1,2,3,4;
//    done_o=0001 on the 6th grant cycle; busy_o low after it.
//  2 req_i=0100, val2=0 -> grant_o=0100 and done_o=0100 both for 1 cycle; cnt_o stays 0.
//  3 req_i=1111 held from reset, all val=2 -> grant order 0,1,2,3,0.
//    Each service is 3 cycles followed by 1 idle cycle.
//  4 req_i=0010 held through done, val1=3 -> requester 1 re-served after 1 idle cycle;
//    done_o pulses every 5 cycles.
//  5 grant to req 0 with val0=10; at cnt_o=4 drop req_i[0] and change val0=1
//    -> count continues to 9 and done_o[0] still pulses.
//  6 rst asserted at cnt_o=3 during a val=8 run -> next cycle: all outputs 0, no done_o;
//    a later req_i=1000 is granted normally.
//  7 val=127 (DWIDTH=7) -> cnt_o reaches 126, done_o follows, and cnt_o never wraps.

Source files
------------

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sharing of one up-counter among NREQ requesters, each with its own terminal count
module counter_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 7,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*DWIDTH-1:0]   cnt_val_i,
  output logic [NREQ-1:0]          grant_o,
  output logic [NREQ-1:0]          done_o,
  output logic                     busy_o,
  output logic [IDW-1:0]           owner_o,
  output logic [DWIDTH-1:0]        cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDW-1:0] owner_q, owner_d, rr_q, rr_d, win;
  logic [DWIDTH-1:0] cnt_q, cnt_d, tgt_q, tgt_d, win_val;
  logic any;
  // descending scan so the last hit is the first requester at or after rr_q
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NREQ-1; i >= 0; i--)
      if (req_i[(int'(rr_q)+i)%NREQ]) begin
        win = IDW'((int'(rr_q)+i)%NREQ);
        any = 1'b1;
      end
  end
  assign win_val = cnt_val_i[int'(win)*DWIDTH +: DWIDTH];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      IDLE: if (any) begin
        grant_d = NREQ'(1) << win;
        owner_d = win;
        tgt_d   = win_val;
        cnt_d   = '0;
        state_d = (win_val == '0) ? DONE : RUN;
      end
      RUN: if (cnt_q == tgt_q - DWIDTH'(1)) state_d = DONE;
           else cnt_d = cnt_q + DWIDTH'(1);
      DONE: begin
        grant_d = '0;
        rr_d    = (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end
  assign grant_o = grant_q;
  assign done_o  = (state_q == DONE) ? grant_q : '0;
  assign busy_o  = state_q != IDLE;
  assign owner_o = owner_q;
  assign cnt_o   = cnt_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed tests against a timeline model of the shared counter
module tb_counter_arbiter;
  localparam int NREQ = 4, DW = 7, IDW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*DW-1:0] val = '0;
  logic [NREQ-1:0] grant, done;
  logic busy;
  logic [IDW-1:0] owner;
  logic [DW-1:0] cnt;
  int vecs = 0, miss = 0;

  counter_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_i(req), .cnt_val_i(val),
    .grant_o(grant), .done_o(done), .busy_o(busy), .owner_o(owner), .cnt_o(cnt));

  always #5 clk = ~clk;

  // a service is a window of V+1 cycles from its grant edge; everything follows from elapsed time
  int cyc = 0, m_start = 0, m_v = 0, m_owner = 0, m_rr = 0, m_cnt = 0, el = 0, k = 0;
  bit m_act = 0, started = 0, found = 0;
  int e_grant = 0, e_done = 0, e_busy = 0;
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act = 0; m_owner = 0; m_rr = 0; m_cnt = 0; started = 1;
    end else if (m_act) begin
      if (cyc - m_start > m_v) begin
        m_act = 0;
        m_rr = (m_owner + 1) % NREQ;
      end
    end else if (req != 0) begin
      found = 0;
      for (int i = 0; i < NREQ; i++)
        if (!found && req[(m_rr+i)%NREQ]) begin k = (m_rr+i)%NREQ; found = 1; end
      m_act = 1; m_start = cyc; m_owner = k;
      m_v = int'(val[k*DW +: DW]);
    end
    if (m_act && !rst) begin
      el = cyc - m_start;
      e_grant = 1 << m_owner;
      e_done = (el == m_v) ? e_grant : 0;
      m_cnt = (m_v == 0) ? 0 : (el < m_v ? el : m_v - 1);
      e_busy = 1;
    end else begin
      e_grant = 0; e_done = 0; e_busy = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("model grant", int'(grant), e_grant);
    chk("model done", int'(done), e_done);
    chk("model busy", int'(busy), e_busy);
    chk("model owner", int'(owner), m_owner);
    chk("model cnt", int'(cnt), m_cnt);
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setv(input int r, input int v);
    val[r*DW +: DW] = DW'(v);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin step(); n++; end
    chk("idle within bound", int'(busy), 0);
  endtask

  initial begin
    int d1, d2, maxc, dcnt;
    bit seen;
    step(2);
    chk("reset grant", int'(grant), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset cnt", int'(cnt), 0);
    // 1: single count of 5
    rst = 0; req = 4'b0001; setv(0, 5);
    step(); req = '0;
    chk("t1 grant", int'(grant), 1);
    chk("t1 cnt0", int'(cnt), 0);
    for (int i = 1; i <= 4; i++) begin step(); chk("t1 cnt", int'(cnt), i); chk("t1 nodone", int'(done), 0); end
    step(); chk("t1 done", int'(done), 1); chk("t1 cnt hold", int'(cnt), 4); chk("t1 grant6", int'(grant), 1);
    step(); chk("t1 busy off", int'(busy), 0); chk("t1 grant off", int'(grant), 0);
    // 2: zero count
    req = 4'b0100; setv(2, 0);
    step(); req = '0;
    chk("t2 grant", int'(grant), 4); chk("t2 done", int'(done), 4); chk("t2 cnt", int'(cnt), 0);
    step(); chk("t2 idle", int'(busy), 0);
    // 3: all requesting from reset
    rst = 1; req = 4'b1111; for (int r = 0; r < NREQ; r++) setv(r, 2);
    step(); rst = 0;
    for (int s = 0; s < 5; s++) begin
      step(); chk("t3 grant order", int'(grant), 1 << (s % NREQ));
      step(2); chk("t3 done", int'(done), 1 << (s % NREQ));
      step(); chk("t3 gap", int'(busy), 0);
    end
    req = '0; step(); wait_idle(10);
    // 4: sole requester held high
    req = 4'b0010; setv(1, 3); d1 = -1; d2 = -1;
    for (int s = 1; s <= 16; s++) begin
      step();
      if (done[1]) begin if (d1 < 0) d1 = s; else if (d2 < 0) d2 = s; end
    end
    chk("t4 first done", d1, 4);
    chk("t4 done period", d2 - d1, 5);
    req = '0; wait_idle(10);
    // 5: inputs changed mid-run are ignored
    req = 4'b0001; setv(0, 10);
    step(); chk("t5 grant", int'(grant), 1);
    step(4); chk("t5 cnt4", int'(cnt), 4);
    req = '0; setv(0, 1);
    step(5); chk("t5 cnt9", int'(cnt), 9);
    step(); chk("t5 done", int'(done), 1);
    step(); chk("t5 idle", int'(busy), 0);
    // 6: reset mid-run
    req = 4'b1000; setv(3, 8);
    step(); chk("t6 grant", int'(grant), 8);
    step(3); chk("t6 cnt3", int'(cnt), 3);
    rst = 1; step();
    chk("t6 rst grant", int'(grant), 0); chk("t6 rst done", int'(done), 0);
    chk("t6 rst busy", int'(busy), 0); chk("t6 rst owner", int'(owner), 0); chk("t6 rst cnt", int'(cnt), 0);
    rst = 0; step(); req = '0;
    chk("t6 regrant", int'(grant), 8);
    wait_idle(20);
    // 7: maximum target
    req = 4'b0001; setv(0, 127);
    step(); req = '0; maxc = 0; seen = 0; dcnt = -1;
    for (int s = 0; s < 200 && !seen; s++) begin
      if (int'(cnt) > maxc) maxc = int'(cnt);
      if (done[0]) begin seen = 1; dcnt = int'(cnt); end
      else step();
    end
    chk("t7 done seen", int'(seen), 1);
    chk("t7 cnt at done", dcnt, 126);
    chk("t7 max cnt", maxc, 126);
    step(); chk("t7 idle", int'(busy), 0);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
